// File: rtl/dump_framer.sv
// dump_framer: wraps a stream of 32-bit SRAM dump words into a self-delimiting
// byte frame for the rsio transmitter:
//   HDR0 HDR1 LEN2 LEN1 LEN0 {payload bytes, MSB first} CKS
// CKS is the two's complement of the 8-bit sum of the LEN and payload bytes,
// so LEN + payload + CKS sums to 8'h00 on the host side.
module dump_framer #(
    parameter logic [7:0]  HDR0  = 8'hA5,
    parameter logic [7:0]  HDR1  = 8'h5A,
    parameter int unsigned CNT_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] frame_words,
    output logic             frame_busy,
    output logic             frame_done,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic [31:0]      word_data,
    output logic             rs_tx_start,
    output logic [7:0]       rs_tx_data,
    input  logic             rs_tx_status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_FETCH,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        B_HDR0,
        B_HDR1,
        B_LEN2,
        B_LEN1,
        B_LEN0,
        B_PAY3,
        B_PAY2,
        B_PAY1,
        B_PAY0,
        B_CKS
    } sel_e;

    state_e             state_q, state_d;
    sel_e               sel_q,   sel_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic [23:0]        len_q,   len_d;
    logic [31:0]        word_q,  word_d;
    logic [7:0]         acc_q,   acc_d;
    logic [7:0]         data_q,  data_d;
    logic               start_q, start_d;

    logic [7:0]         byte_cur;
    logic               byte_counted;

    // Byte currently selected for transmission, and whether it enters the checksum.
    always_comb begin
        byte_cur = '0;
        case (sel_q)
            B_HDR0:  byte_cur = HDR0;
            B_HDR1:  byte_cur = HDR1;
            B_LEN2:  byte_cur = len_q[23:16];
            B_LEN1:  byte_cur = len_q[15:8];
            B_LEN0:  byte_cur = len_q[7:0];
            B_PAY3:  byte_cur = word_q[31:24];
            B_PAY2:  byte_cur = word_q[23:16];
            B_PAY1:  byte_cur = word_q[15:8];
            B_PAY0:  byte_cur = word_q[7:0];
            B_CKS:   byte_cur = ~acc_q + 8'd1;
            default: byte_cur = '0;
        endcase
        byte_counted = (sel_q != B_HDR0) && (sel_q != B_HDR1) && (sel_q != B_CKS);
    end

    // Next-state logic: sequence bytes, pace them against the transmitter, pull words.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        len_d   = len_q;
        word_d  = word_q;
        acc_d   = acc_q;
        data_d  = data_q;
        start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    rem_d   = frame_words;
                    len_d   = 24'(frame_words);
                    acc_d   = '0;
                    sel_d   = B_HDR0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!rs_tx_status) begin
                    start_d = 1'b1;
                    data_d  = byte_cur;
                    if (byte_counted) begin
                        acc_d = acc_q + byte_cur;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // start_q is high only in the first WAIT cycle; status is not
                // yet valid for this byte there, so that cycle is skipped.
                if (!start_q && !rs_tx_status) begin
                    case (sel_q)
                        B_LEN0, B_PAY0: begin
                            if (rem_q != '0) begin
                                state_d = S_FETCH;
                            end else begin
                                sel_d   = B_CKS;
                                state_d = S_SEND;
                            end
                        end
                        B_CKS: begin
                            state_d = S_DONE;
                        end
                        default: begin
                            sel_d   = sel_e'(sel_q + 4'd1);
                            state_d = S_SEND;
                        end
                    endcase
                end
            end
            S_FETCH: begin
                if (word_valid) begin
                    word_d  = word_data;
                    rem_d   = rem_q - CNT_W'(1);
                    sel_d   = B_PAY3;
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= B_HDR0;
            rem_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign frame_busy  = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_FETCH);
    assign frame_done  = (state_q == S_DONE);
    assign word_ready  = (state_q == S_FETCH);
    assign rs_tx_start = start_q;
    assign rs_tx_data  = data_q;

endmodule

// File: tb/tb_dump_framer.sv
// Directed bench for dump_framer: a transmitter model, a word source model and
// a byte scoreboard fed from a reference frame image built by the bench.
module tb_dump_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [17:0] frame_words;
    logic        frame_busy;
    logic        frame_done;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        rs_tx_start;
    logic [7:0]  rs_tx_data;
    logic        rs_tx_status;

    dump_framer #(
        .HDR0  (8'hA5),
        .HDR1  (8'h5A),
        .CNT_W (18)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .frame_words  (frame_words),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .rs_tx_start  (rs_tx_start),
        .rs_tx_data   (rs_tx_data),
        .rs_tx_status (rs_tx_status)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] src_q[$];
    logic [31:0] wbuf[$];

    int         nbytes = 0;
    int         ndone  = 0;
    int         nready = 0;
    int         nhs    = 0;
    int         rx_idx = 0;
    logic [7:0] rx_sum = '0;
    logic [7:0] last_byte = '0;
    logic       prev_start = 1'b0;
    logic       prev_done  = 1'b0;
    int         src_gap = 0;
    int         gap_cnt = 0;
    int         busy_cnt = 0;
    logic       stall = 1'b0;
    int         b0, d0, h0, r0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Transmitter: busy for 10 cycles after each start pulse, plus an external stall.
    always @(posedge clk) begin
        if (rs_tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign rs_tx_status = (busy_cnt != 0) || stall;

    // Word source: offers the next queued word after src_gap cycles of word_ready.
    initial begin
        word_valid = 1'b0;
        word_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                word_valid = 1'b0;
                src_q.delete();
                gap_cnt = 0;
            end else begin
                if (!word_valid && word_ready && src_q.size() > 0) begin
                    if (gap_cnt >= src_gap) begin
                        word_valid = 1'b1;
                        word_data  = src_q[0];
                    end else begin
                        gap_cnt++;
                    end
                end
                if (word_valid && word_ready) begin
                    @(posedge clk);
                    #1;
                    void'(src_q.pop_front());
                    nhs++;
                    word_valid = 1'b0;
                    gap_cnt = 0;
                end
            end
        end
    end

    // Output monitor: scoreboard compare of every launched byte.
    always @(posedge clk) begin
        #1;
        if (rs_tx_start) begin
            chk("start_width", 32'(prev_start), 32'd0);
            chk("start_in_fetch", 32'(word_ready), 32'd0);
            chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                chk($sformatf("byte%0d", rx_idx), 32'(rs_tx_data), 32'(exp_q.pop_front()));
            end
            if (rx_idx >= 2) rx_sum = rx_sum + rs_tx_data;
            last_byte = rs_tx_data;
            rx_idx++;
            nbytes++;
        end
        if (frame_done) begin
            chk("done_width", 32'(prev_done), 32'd0);
            ndone++;
        end
        if (word_ready) nready++;
        prev_start = rs_tx_start;
        prev_done  = frame_done;
    end

    // Builds the expected frame from wbuf, queues the words, and requests the frame.
    task automatic start_frame(input int gap);
        logic [7:0]  acc;
        logic [7:0]  bt;
        logic [23:0] len;
        logic [31:0] w;
        acc = '0;
        len = 24'(wbuf.size());
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 2; i >= 0; i--) begin
            bt = len[i*8 +: 8];
            exp_q.push_back(bt);
            acc = acc + bt;
        end
        foreach (wbuf[k]) begin
            w = wbuf[k];
            for (int i = 3; i >= 0; i--) begin
                bt = w[i*8 +: 8];
                exp_q.push_back(bt);
                acc = acc + bt;
            end
            src_q.push_back(w);
        end
        exp_q.push_back(8'(0 - acc));
        src_gap = gap;
        rx_idx  = 0;
        rx_sum  = '0;
        b0 = nbytes; d0 = ndone; h0 = nhs; r0 = nready;
        @(negedge clk);
        frame_start = 1'b1;
        frame_words = 18'(wbuf.size());
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (nbytes < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_bytes", (nbytes >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Waits for frame_done, then checks the frame totals; optionally pokes
    // frame_start in the frame_done cycle, which must be ignored.
    task automatic finish_frame(input bit poke_on_done);
        int t = 0;
        int low = 0;
        int n = wbuf.size();
        int nb;
        while (!frame_done && t < 20000) begin
            if (!frame_busy) low++;
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(frame_done), 32'd1);
        chk("busy_low_in_frame", 32'(low), 32'd0);
        chk("busy_in_done", 32'(frame_busy), 32'd0);
        if (poke_on_done) begin
            frame_start = 1'b1;
            frame_words = 18'd2;
        end
        @(negedge clk);
        frame_start = 1'b0;
        nb = nbytes;
        repeat (30) @(negedge clk);
        chk("no_bytes_after_done", 32'(nbytes), 32'(nb));
        chk("idle_after_done", 32'(frame_busy), 32'd0);
        chk("byte_count", 32'(nbytes - b0), 32'(6 + 4 * n));
        chk("handshakes", 32'(nhs - h0), 32'(n));
        chk("done_count", 32'(ndone - d0), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("sum_zero", 32'(rx_sum), 32'd0);
    endtask

    initial begin
        int nb;
        int nd;
        logic [7:0] dh;
        int changes;

        reset = 1'b1;
        frame_start = 1'b0;
        frame_words = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_start", 32'(rs_tx_start), 32'd0);
        chk("rst_data", 32'(rs_tx_data), 32'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // One word, back-to-back source.
        wbuf.delete();
        wbuf.push_back(32'h01020304);
        start_frame(0);
        finish_frame(1'b0);
        chk("t1_cks", 32'(last_byte), 32'hF5);

        // Empty frame: no word_ready at all.
        wbuf.delete();
        start_frame(0);
        finish_frame(1'b0);
        chk("t2_no_ready", 32'(nready - r0), 32'd0);
        chk("t2_cks", 32'(last_byte), 32'h00);

        // Three random words with a slow source.
        wbuf.delete();
        repeat (3) wbuf.push_back($urandom());
        start_frame(50);
        finish_frame(1'b0);

        // Extra frame_start while busy, and one in the frame_done cycle.
        wbuf.delete();
        wbuf.push_back(32'hDEADBEEF);
        start_frame(0);
        repeat (20) @(negedge clk);
        frame_start = 1'b1;
        frame_words = 18'd2;
        @(negedge clk);
        frame_start = 1'b0;
        finish_frame(1'b1);

        // Reset during the fifth payload byte aborts the frame.
        wbuf.delete();
        wbuf.push_back(32'h11223344);
        wbuf.push_back(32'h55667788);
        start_frame(0);
        wait_bytes(b0 + 10);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_start", 32'(rs_tx_start), 32'd0);
        chk("abort_ready", 32'(word_ready), 32'd0);
        chk("abort_busy", 32'(frame_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        nb = nbytes;
        nd = ndone;
        repeat (40) @(negedge clk);
        chk("abort_no_bytes", 32'(nbytes), 32'(nb));
        chk("abort_no_done", 32'(ndone), 32'(nd));
        wbuf.delete();
        wbuf.push_back(32'hCAFEF00D);
        wbuf.push_back(32'h0000FFFF);
        start_frame(0);
        finish_frame(1'b0);

        // Transmitter stalled for 1000 cycles after the second byte.
        wbuf.delete();
        wbuf.push_back(32'h80FF7F01);
        start_frame(0);
        wait_bytes(b0 + 2);
        stall = 1'b1;
        dh = rs_tx_data;
        nb = nbytes;
        changes = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rs_tx_data !== dh) changes++;
        end
        chk("stall_no_start", 32'(nbytes), 32'(nb));
        chk("stall_data_held", 32'(changes), 32'd0);
        chk("stall_data_val", 32'(dh), 32'h5A);
        stall = 1'b0;
        finish_frame(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
